// File: rtl/pipeline_queue.sv
// Elastic valid/ready pipeline register: DEPTH-entry circular queue of WIDTH-bit
// payloads with synchronous reset and flush that clear pointers and occupancy.
module pipeline_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]               r_count;
  logic                        w_push, w_pop, w_clear;

  // Handshake flags come only from registered occupancy, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  assign w_clear = rst | flush;
  assign w_push  = in_valid & in_ready & ~w_clear;
  assign w_pop   = out_valid & out_ready & ~w_clear;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is not reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end
endmodule
